// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool definitions used by the Miyaguchi-Preneel chaining
// controller, the cipher core and the HMAC sequencer.
//   BLOCK_W  : width of a message block, key and chaining value
//   IV_ZERO  : plain-Whirlpool initial chaining value
//   state_t  : chaining controller state encoding
//   mp_fold  : Miyaguchi-Preneel feed-forward H' = E_H(m) ^ H ^ m
package whirlpool_pkg;

  localparam int BLOCK_W = 512;
  localparam logic [BLOCK_W-1:0] IV_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic [BLOCK_W-1:0] mp_fold(
    input logic [BLOCK_W-1:0] cipher_out,
    input logic [BLOCK_W-1:0] h,
    input logic [BLOCK_W-1:0] m
  );
    return cipher_out ^ h ^ m;
  endfunction

endpackage

// File: rtl/whirlpool_mp_chain.sv
// Miyaguchi-Preneel chaining controller for Whirlpool. Accepts padded
// 512-bit blocks, runs the external cipher core with m as plaintext and the
// chaining value H as key, folds the result back into H and emits the final
// H of each message as the digest.
// Ports:
//   i_clk, i_rstn                    clock, async active-low reset
//   i_blk_valid/o_blk_ready          block stream handshake
//   i_blk_data, i_blk_first/last     block payload and message framing
//   i_iv                             chaining value loaded on a first block
//   o_cipher_init/data/key           start pulse, plaintext m, key H
//   i_cipher_out/valid               cipher result and its strobe
//   o_digest/valid, i_digest_ready   digest output handshake
//   o_block_cnt                      blocks processed since last first block
module whirlpool_mp_chain
  import whirlpool_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_blk_valid,
  output logic               o_blk_ready,
  input  logic [BLOCK_W-1:0] i_blk_data,
  input  logic               i_blk_first,
  input  logic               i_blk_last,
  input  logic [BLOCK_W-1:0] i_iv,
  output logic               o_cipher_init,
  output logic [BLOCK_W-1:0] o_cipher_data,
  output logic [BLOCK_W-1:0] o_cipher_key,
  input  logic [BLOCK_W-1:0] i_cipher_out,
  input  logic               i_cipher_valid,
  output logic [BLOCK_W-1:0] o_digest,
  output logic               o_digest_valid,
  input  logic               i_digest_ready,
  output logic [CNT_W-1:0]   o_block_cnt
);

  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] h_q, m_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               init_q;
  logic               dvalid_q;

  logic blk_hs;
  logic result_hs;

  assign blk_hs    = (state_q == IDLE) && i_blk_valid;
  // A strobe outside WAIT is spurious and must not touch H or the state.
  assign result_hs = (state_q == WAIT) && i_cipher_valid;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (blk_hs)         state_d = START;
      START:                     state_d = WAIT;
      WAIT:  if (i_cipher_valid) state_d = last_q ? OUT : IDLE;
      OUT:   if (i_digest_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the wide H/m registers are reset as well, so a reset mid-message
  // discards the in-flight chaining value and the core never sees stale keys.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_q      <= IV_ZERO;
      m_q      <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      init_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      // Start pulse lands in START, exactly one cycle after the handshake.
      init_q <= blk_hs;

      if (blk_hs) begin
        m_q    <= i_blk_data;
        last_q <= i_blk_last;
        if (i_blk_first) begin
          h_q   <= i_iv;
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      if (result_hs) begin
        h_q <= mp_fold(i_cipher_out, h_q, m_q);
      end

      if (result_hs && last_q) begin
        dvalid_q <= 1'b1;
      end else if ((state_q == OUT) && i_digest_ready) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  assign o_blk_ready    = (state_q == IDLE);
  assign o_cipher_init  = init_q;
  assign o_cipher_data  = m_q;
  assign o_cipher_key   = h_q;
  // H only changes on a result strobe in WAIT, so it is stable throughout OUT.
  assign o_digest       = h_q;
  assign o_digest_valid = dvalid_q;
  assign o_block_cnt    = cnt_q;

endmodule
